axi4_lite_master_bridge: RTL and testbench

- Single-outstanding AXI4-Lite master (initiator): turns a simple request/response interface into AXI4-Lite read and write transactions.
- Sits between control logic (a command sequencer or a self-test engine) and an AXI4-Lite slave such as axi4_lite_gpu's control port.
- Drives all five channels and returns read data plus response code.
- Provides a watchdog flag for slaves that never respond.

---
 rtl/axi4_lite_pkg.sv | 19 +
 rtl/axi4_lite_master_bridge_if.sv | 37 +++
 rtl/axi4_lite_master_bridge.sv | 140 ++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, master FSM states, default protection.
package axi4_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WR_AW_W,
    M_WR_B,
    M_RD_AR,
    M_RD_R
  } mst_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axi4_lite_master_bridge_if.sv
// AXI4-Lite five-channel bundle; master drives AW/W/AR valids and B/R readies.
interface axi4_lite_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master: one request in, one AXI transaction out,
// one response back. Sticky hang flag if the slave stalls a phase too long.
module axi4_lite_master_bridge
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          hang,
  axi4_lite_master_bridge_if.master     m_axi
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mst_state_t                     state, state_nxt;
  logic                           aw_done, w_done;
  logic                           aw_vld, w_vld, b_rdy, ar_vld, r_rdy;
  logic                           accept, wd_run;
  logic [AXI_ADDRESS_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]      wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0]    wstrb_q;
  logic [CW-1:0]                  wd_cnt;

  // Reset gating keeps req_ready low while the block is held in reset.
  assign req_ready = m_axi_aresetn && (state == M_IDLE) && !rsp_valid;
  assign accept    = req_valid && req_ready;
  assign wd_run    = (state != M_IDLE) && (state_nxt == state);

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.awprot  = PROT_DEFAULT;
  assign m_axi.arprot  = PROT_DEFAULT;
  assign m_axi.awvalid = aw_vld;
  assign m_axi.wvalid  = w_vld;
  assign m_axi.bready  = b_rdy;
  assign m_axi.arvalid = ar_vld;
  assign m_axi.rready  = r_rdy;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= M_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aw_vld    = 1'b0;
    w_vld     = 1'b0;
    b_rdy     = 1'b0;
    ar_vld    = 1'b0;
    r_rdy     = 1'b0;
    case (state)
      M_IDLE:
        if (accept) state_nxt = req_write ? M_WR_AW_W : M_RD_AR;
      M_WR_AW_W: begin
        // AW and W complete independently, in either order or together.
        aw_vld = !aw_done;
        w_vld  = !w_done;
        if ((aw_done || m_axi.awready) && (w_done || m_axi.wready))
          state_nxt = M_WR_B;
      end
      M_WR_B: begin
        b_rdy = 1'b1;
        if (m_axi.bvalid) state_nxt = M_IDLE;
      end
      M_RD_AR: begin
        ar_vld = 1'b1;
        if (m_axi.arready) state_nxt = M_RD_R;
      end
      M_RD_R: begin
        r_rdy = 1'b1;
        if (m_axi.rvalid) state_nxt = M_IDLE;
      end
      default: state_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      wd_cnt    <= '0;
      hang      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state == M_WR_AW_W) begin
        if (aw_vld && m_axi.awready) aw_done <= 1'b1;
        if (w_vld && m_axi.wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end else if (state == M_WR_B && m_axi.bvalid) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axi.bresp;
      end else if (state == M_RD_R && m_axi.rvalid) begin
        rsp_valid <= 1'b1;
        rsp_write <= 1'b0;
        rsp_rdata <= m_axi.rdata;
        rsp_resp  <= m_axi.rresp;
      end
      // Watchdog counts cycles spent in one non-idle state; the bus stays pending.
      if (!wd_run)                             wd_cnt <= '0;
      else if (wd_cnt != CW'(TIMEOUT_CYCLES))  wd_cnt <= wd_cnt + 1'b1;
      if (accept)
        hang <= 1'b0;
      else if (wd_run && wd_cnt == CW'(TIMEOUT_CYCLES - 1))
        hang <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench for axi4_lite_master_bridge plus a randomized-latency slave phase.
module tb_axi4_lite_master_bridge;
  import axi4_lite_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        hang;

  int checks = 0;
  int errors = 0;

  axi4_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) m ();

  axi4_lite_master_bridge #(
    .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .hang(hang),
    .m_axi(m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave / monitor state, only touched from the single stimulus process
  logic        auto_en;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        pend_aw, pend_w, pend_ar;
  logic [31:0] pend_awaddr, pend_wdata, pend_araddr;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic        have_aw, have_w, have_ar;
  int          aw_d, w_d, b_d, ar_d, r_d;
  logic [31:0] mem   [16];
  logic [31:0] model [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, return #1 after posedge.
  task automatic cycle();
    @(negedge clk);
    aw_hs = m.awvalid && m.awready;
    w_hs  = m.wvalid  && m.wready;
    b_hs  = m.bvalid  && m.bready;
    ar_hs = m.arvalid && m.arready;
    r_hs  = m.rvalid  && m.rready;
    if (aw_hs) s_awaddr = m.awaddr;
    if (w_hs) begin s_wdata = m.wdata; s_wstrb = m.wstrb; end
    if (ar_hs) s_araddr = m.araddr;
    if (auto_en) begin
      if (pend_aw) chk("aw_hold", {m.awvalid, m.awaddr}, {1'b1, pend_awaddr});
      if (pend_w)  chk("w_hold",  {m.wvalid,  m.wdata},  {1'b1, pend_wdata});
      if (pend_ar) chk("ar_hold", {m.arvalid, m.araddr}, {1'b1, pend_araddr});
    end
    pend_aw = m.awvalid && !m.awready; pend_awaddr = m.awaddr;
    pend_w  = m.wvalid  && !m.wready;  pend_wdata  = m.wdata;
    pend_ar = m.arvalid && !m.arready; pend_araddr = m.araddr;
    @(posedge clk);
    #1;
    if (auto_en) begin
      if (aw_hs) begin m.awready = 1'b0; have_aw = 1'b1; end
      else if (m.awvalid && !m.awready) begin
        if (aw_d < 0) aw_d = $urandom_range(0, 3);
        if (aw_d == 0) begin m.awready = 1'b1; aw_d = -1; end else aw_d--;
      end
      if (w_hs) begin m.wready = 1'b0; have_w = 1'b1; end
      else if (m.wvalid && !m.wready) begin
        if (w_d < 0) w_d = $urandom_range(0, 3);
        if (w_d == 0) begin m.wready = 1'b1; w_d = -1; end else w_d--;
      end
      if (b_hs) m.bvalid = 1'b0;
      else if (have_aw && have_w && !m.bvalid) begin
        if (b_d < 0) b_d = $urandom_range(0, 3);
        if (b_d == 0) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
          m.bvalid = 1'b1; m.bresp = OKAY;
          have_aw = 1'b0; have_w = 1'b0; b_d = -1;
        end else b_d--;
      end
      if (ar_hs) begin m.arready = 1'b0; have_ar = 1'b1; end
      else if (m.arvalid && !m.arready) begin
        if (ar_d < 0) ar_d = $urandom_range(0, 3);
        if (ar_d == 0) begin m.arready = 1'b1; ar_d = -1; end else ar_d--;
      end
      if (r_hs) m.rvalid = 1'b0;
      else if (have_ar && !m.rvalid) begin
        if (r_d < 0) r_d = $urandom_range(0, 3);
        if (r_d == 0) begin
          m.rdata = mem[s_araddr[5:2]]; m.rresp = OKAY; m.rvalid = 1'b1;
          have_ar = 1'b0; r_d = -1;
        end else r_d--;
      end
    end
  endtask

  initial begin
    logic        wr;
    logic [3:0]  idx, strb;
    logic [31:0] data;
    int          g;

    auto_en = 1'b0; rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 0;
    m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = '0;
    m.arready = 0; m.rvalid = 0; m.rdata = '0; m.rresp = '0;
    pend_aw = 0; pend_w = 0; pend_ar = 0;
    have_aw = 0; have_w = 0; have_ar = 0;
    aw_d = -1; w_d = -1; b_d = -1; ar_d = -1; r_d = -1;

    // reset state
    #12;
    chk("rst_valids", {m.awvalid, m.wvalid, m.arvalid, m.bready, m.rready}, 5'b0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 36'h0);
    chk("rst_hang_ready", {hang, req_ready}, 2'b00);
    chk("rst_addr_prot", {m.awaddr, m.awprot, m.arprot}, 38'h0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    chk("idle_req_ready", req_ready, 1'b1);

    // zero-wait read
    m.arready = 1; req_write = 0; req_addr = 32'h1; req_valid = 1;
    cycle();
    req_valid = 0;
    chk("t1_arvalid_c1", {m.arvalid, m.araddr}, {1'b1, 32'h1});
    cycle();
    chk("t1_arvalid_c2", m.arvalid, 1'b0);
    chk("t1_rready", m.rready, 1'b1);
    m.arready = 0; m.rvalid = 1; m.rdata = 32'hFFFF_FFFF; m.rresp = OKAY;
    cycle();
    m.rvalid = 0;
    chk("t1_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF});
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;
    chk("t1_rsp_clear", {rsp_valid, req_ready}, 2'b01);

    // write, W handshakes at cycle 1, AW at cycle 4
    req_write = 1; req_addr = 32'h0; req_wdata = 32'h0078_0FE3; req_wstrb = 4'hF; req_valid = 1;
    cycle();
    req_valid = 0;
    chk("t2_aw_w_c1", {m.awvalid, m.wvalid, m.wdata, m.wstrb}, {2'b11, 32'h0078_0FE3, 4'hF});
    m.wready = 1;
    cycle();
    m.wready = 0;
    chk("t2_c2", {m.awvalid, m.wvalid, m.bready}, 3'b100);
    cycle();
    chk("t2_c3", {m.awvalid, m.wvalid, m.bready}, 3'b100);
    cycle();
    chk("t2_c4", {m.awvalid, m.wvalid, m.bready}, 3'b100);
    m.awready = 1;
    cycle();
    m.awready = 0;
    chk("t2_bready", {m.awvalid, m.wvalid, m.bready}, 3'b001);
    m.bvalid = 1; m.bresp = OKAY;
    cycle();
    m.bvalid = 0;
    chk("t2_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 32'h0});
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;

    // SLVERR read held under backpressure, queued write behind it
    m.arready = 1; req_write = 0; req_addr = 32'h10; req_valid = 1;
    cycle();
    req_valid = 0;
    cycle();
    m.arready = 0; m.rvalid = 1; m.rdata = 32'hA5A5_A5A5; m.rresp = SLVERR;
    cycle();
    m.rvalid = 0;
    chk("t3_rsp", {rsp_valid, rsp_resp}, {1'b1, 2'b10});
    req_write = 1; req_addr = 32'h8; req_wdata = 32'h1234_5678; req_wstrb = 4'h3; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_hold", {rsp_valid, rsp_resp, rsp_rdata, req_ready}, {1'b1, 2'b10, 32'hA5A5_A5A5, 1'b0});
    end
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;
    chk("t3_released", {rsp_valid, req_ready, m.awvalid}, 3'b010);
    cycle();
    req_valid = 0;
    chk("t3_accept_next", {m.awvalid, m.awaddr, req_ready}, {1'b1, 32'h8, 1'b0});
    m.awready = 1; m.wready = 1;
    cycle();
    m.awready = 0; m.wready = 0;
    chk("t3_simul_aw_w", {m.awvalid, m.wvalid, m.bready}, 3'b001);
    m.bvalid = 1; m.bresp = DECERR;
    cycle();
    m.bvalid = 0;
    chk("t3_decerr", {rsp_valid, rsp_write, rsp_resp}, {1'b1, 1'b1, 2'b11});
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;

    // hang: slave never takes AR
    req_write = 0; req_addr = 32'h20; req_valid = 1;
    cycle();
    req_valid = 0;
    for (int i = 1; i < 8; i++) begin
      cycle();
      chk("t4_pre_hang", {hang, m.arvalid}, 2'b01);
    end
    cycle();
    chk("t4_hang_set", {hang, m.arvalid}, 2'b11);
    repeat (3) cycle();
    chk("t4_hang_sticky", {hang, m.arvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_reset", {hang, m.arvalid, req_ready}, 3'b000);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("t4_after_reset", {hang, req_ready}, 2'b01);

    // random traffic against a memory model
    for (int i = 0; i < 16; i++) begin mem[i] = '0; model[i] = '0; end
    auto_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      wr   = 1'($urandom_range(0, 1));
      idx  = 4'($urandom_range(0, 15));
      data = $urandom;
      strb = 4'($urandom_range(1, 15));
      req_write = wr; req_addr = {26'h0, idx, 2'b00}; req_wdata = data; req_wstrb = strb;
      req_valid = 1;
      g = 0;
      while (!req_ready && g < 20) begin cycle(); g++; end
      chk("rnd_req_ready", req_ready, 1'b1);
      cycle();
      req_valid = 0;
      if (wr)
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      g = 0;
      while (!rsp_valid && g < 60) begin cycle(); g++; end
      chk("rnd_rsp_valid", rsp_valid, 1'b1);
      if (rsp_valid) begin
        chk("rnd_rsp_meta", {rsp_write, rsp_resp}, {wr, 2'b00});
        if (!wr) chk("rnd_rdata", rsp_rdata, model[idx]);
        repeat ($urandom_range(0, 3)) cycle();
        rsp_ready = 1;
        cycle();
        rsp_ready = 0;
      end
    end
    auto_en = 1'b0;
    chk("rnd_no_hang", hang, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
